// File: rtl/ps2_rx_frame_ctrl_if.sv
// Signal bundle between the PS/2 debouncers, the frame controller and the scancode decoder.
// master drives the PS/2 lines, enable and ready; slave is the frame controller.
interface ps2_rx_frame_ctrl_if;
  logic       ps2_clk_db;
  logic       ps2_data_db;
  logic       rx_en;
  logic       code_ready;
  logic [7:0] code_out;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output ps2_clk_db, ps2_data_db, rx_en, code_ready,
    input  code_out, code_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  ps2_clk_db, ps2_data_db, rx_en, code_ready,
    output code_out, code_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 receive framer: 11-bit frame capture, odd-parity/stop checking, inter-edge timeout,
// and a one-entry valid/ready holding register for the received scancode.
module ps2_rx_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 13
) (
  input  logic              cclk,
  input  logic              clr,
  ps2_rx_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_clk_prev;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [7:0]       r_code_out;
  logic             r_code_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_fall;
  logic w_data;
  logic w_act;
  logic w_tmo_hit;
  logic w_frame_err_nxt;
  logic w_parity_err_nxt;
  logic w_good;
  logic w_load;
  logic w_overrun_nxt;

  assign w_fall    = r_clk_prev & ~bus.ps2_clk_db;
  assign w_data    = bus.ps2_data_db;
  assign w_act     = w_fall & bus.rx_en;
  assign w_tmo_hit = (r_state != S_IDLE) && bus.rx_en && !w_fall && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // rx_en low aborts any frame in progress ahead of edge or timeout handling
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_act && !w_data) w_state_nxt = S_DATA;
    end else if (!bus.rx_en || w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_frame_err_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_good           = 1'b0;
    if (w_tmo_hit) w_frame_err_nxt = 1'b1;
    if (w_act) begin
      case (r_state)
        S_IDLE: if (w_data) w_frame_err_nxt = 1'b1;
        S_STOP: begin
          if (!w_data)                  w_frame_err_nxt  = 1'b1;
          else if (!(^{r_shift, r_par})) w_parity_err_nxt = 1'b1;
          else                          w_good           = 1'b1;
        end
        default: ;
      endcase
    end
    w_load        = w_good & (~r_code_valid | bus.code_ready);
    w_overrun_nxt = w_good & r_code_valid & ~bus.code_ready;
  end

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      r_clk_prev   <= 1'b1;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par        <= 1'b0;
      r_tmo_cnt    <= '0;
      r_code_out   <= '0;
      r_code_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_clk_prev   <= bus.ps2_clk_db;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_overrun    <= w_overrun_nxt;

      if (w_act) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par <= w_data;
          default: ;
        endcase
      end

      if (r_state == S_IDLE || w_state_nxt == S_IDLE || w_fall)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);

      if (w_load) begin
        r_code_out   <= r_shift;
        r_code_valid <= 1'b1;
      end else if (r_code_valid && bus.code_ready) begin
        r_code_valid <= 1'b0;
      end
    end
  end

  assign bus.code_out   = r_code_out;
  assign bus.code_valid = r_code_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule
